// File: rtl/imem_responder_pkg.sv
// rtl/imem_responder_pkg.sv - shared state encoding, constants and LFSR step for the imem responder
package imem_responder_pkg;

  typedef enum logic [1:0] {
    IMEM_IDLE = 2'd0,
    IMEM_WAIT = 2'd1,
    IMEM_RESP = 2'd2
  } imem_state_t;

  localparam logic [1:0] S_IDLE = IMEM_IDLE;
  localparam logic [1:0] S_WAIT = IMEM_WAIT;
  localparam logic [1:0] S_RESP = IMEM_RESP;

  localparam logic [15:0] IMEM_NOP = 16'h0000;

  // Fibonacci taps 8,6,5,4 map to bits 7,5,4,3
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/imem_stall_lfsr.sv
// rtl/imem_stall_lfsr.sv - 8-bit LFSR producing 0..3 extra wait cycles per accepted fetch
import imem_responder_pkg::*;

module imem_stall_lfsr (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_advance,
  output logic [1:0] o_stall
);

  logic [7:0] r_lfsr;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_lfsr <= LFSR_SEED;
    end else if (i_advance) begin
      r_lfsr <= lfsr_step(r_lfsr);
    end
  end

  // the value before the step applies to the request being accepted
  assign o_stall = r_lfsr[1:0];

endmodule

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - instruction RAM answering LC3 fetches after a programmable latency
// IMEM_RAND_STALL_EN adds 0..3 LFSR-driven wait cycles per request.
import imem_responder_pkg::*;

module imem_responder #(
  parameter int          ADDR_BITS    = 8,
  parameter int          READ_LATENCY = 2,
  parameter logic [15:0] OOR_INSTR    = IMEM_NOP
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [15:0]          i_pc,
  input  logic                 i_instrmem_rd,
  output logic [15:0]          o_instr_dout,
  output logic                 o_complete_instr,
  input  logic                 i_load_en,
  input  logic [ADDR_BITS-1:0] i_load_addr,
  input  logic [15:0]          i_load_data,
  output logic                 o_busy
);

`ifdef IMEM_RAND_STALL_EN
  localparam int CNT_W = 5;
`else
  localparam int CNT_W = 4;
`endif

  logic [1:0]       r_state;
  logic [15:0]      r_pc_q;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_dout;
  logic             r_complete;
  logic [15:0]      r_ram [2**ADDR_BITS];

  logic             w_accept;
  logic             w_oor;
  logic [CNT_W-1:0] w_lat_m1;
  logic [15:0]      w_rd_data;

  assign w_accept = (r_state == S_IDLE) && i_instrmem_rd;

`ifdef IMEM_RAND_STALL_EN
  logic [1:0] w_stall;

  imem_stall_lfsr u_stall_lfsr (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_advance (w_accept),
    .o_stall   (w_stall)
  );

  assign w_lat_m1 = CNT_W'(READ_LATENCY - 1) + CNT_W'(w_stall);
`else
  assign w_lat_m1 = CNT_W'(READ_LATENCY - 1);
`endif

  assign w_oor     = |r_pc_q[15:ADDR_BITS];
  assign w_rd_data = w_oor ? OOR_INSTR : r_ram[r_pc_q[ADDR_BITS-1:0]];

  // no reset here: program loads must land even while reset is held
  always_ff @(posedge i_clock) begin
    if (i_load_en) begin
      r_ram[i_load_addr] <= i_load_data;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_pc_q     <= 16'h0000;
      r_cnt      <= '0;
      r_dout     <= 16'h0000;
      r_complete <= 1'b0;
    end else begin
      r_complete <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_instrmem_rd) begin
            r_pc_q  <= i_pc;
            r_cnt   <= w_lat_m1;
            r_state <= (w_lat_m1 == '0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          // RAM read sees the pre-edge contents, so a colliding load returns old data
          r_dout     <= w_rd_data;
          r_complete <= 1'b1;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_instr_dout     = r_dout;
  assign o_complete_instr = r_complete;
  assign o_busy           = (r_state != S_IDLE);

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - directed and randomized fetch checks against a memory/latency model
module tb_imem_responder;

  localparam int RL = 2;

  logic        clk = 1'b0;
  logic        i_reset;
  logic [15:0] i_pc;
  logic        i_rd;
  logic [15:0] o_dout;
  logic        o_complete;
  logic        i_load_en;
  logic [7:0]  i_load_addr;
  logic [15:0] i_load_data;
  logic        o_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [15:0] mem_m [256];
`ifdef IMEM_RAND_STALL_EN
  logic [7:0] lfsr_m;
`endif

  imem_responder dut (
    .i_clock          (clk),
    .i_reset          (i_reset),
    .i_pc             (i_pc),
    .i_instrmem_rd    (i_rd),
    .o_instr_dout     (o_dout),
    .o_complete_instr (o_complete),
    .i_load_en        (i_load_en),
    .i_load_addr      (i_load_addr),
    .i_load_data      (i_load_data),
    .o_busy           (o_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
`ifdef IMEM_RAND_STALL_EN
    lfsr_m = 8'hA5;
`endif
  endtask

  // expected latency of the next accepted request; advances the stall model
  function automatic int next_latency();
    int lat;
    lat = RL;
`ifdef IMEM_RAND_STALL_EN
    lat = lat + int'(lfsr_m[1:0]);
    lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
`endif
    return lat;
  endfunction

  // called at a negedge
  task automatic load(input logic [7:0] a, input logic [15:0] d);
    i_load_en = 1'b1;
    i_load_addr = a;
    i_load_data = d;
    @(negedge clk);
    i_load_en = 1'b0;
    mem_m[a] = d;
  endtask

  // called at a negedge with the DUT idle; returns at the negedge of the strobe cycle
  task automatic fetch(input logic [15:0] a, input bit drop, input bit col, input logic [15:0] col_d,
                       output int strobe_cyc, output int exp_lat);
    logic [15:0] exp_d;
    int k;
    bit seen;
    exp_d = (a[15:8] != 8'h00) ? 16'h0000 : mem_m[a[7:0]];
    exp_lat = next_latency();
    i_pc = a;
    i_rd = 1'b1;
    @(posedge clk);
    k = 0;
    seen = 1'b0;
    strobe_cyc = 0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      i_pc = 16'($urandom);
      if (drop) i_rd = 1'b0;
      if (i_load_en) begin
        mem_m[i_load_addr] = i_load_data;
        i_load_en = 1'b0;
      end
      if (o_complete) begin
        seen = 1'b1;
        strobe_cyc = cyc;
      end else begin
        chk("busy_in_flight", 32'(o_busy), 32'd1);
        if (col && k == exp_lat) begin
          i_load_en = 1'b1;
          i_load_addr = a[7:0];
          i_load_data = col_d;
        end
      end
    end
    i_rd = 1'b0;
    if (!seen) begin
      chk("strobe_timeout", 32'd0, 32'd1);
    end else begin
      chk("latency", 32'(k - 1), 32'(exp_lat));
      chk("data", 32'(o_dout), 32'(exp_d));
      chk("busy_at_strobe", 32'(o_busy), 32'd0);
`ifdef IMEM_RAND_STALL_EN
      chk("latency_range", 32'((k - 1 >= 2) && (k - 1 <= 5)), 32'd1);
`endif
    end
  endtask

  initial begin
    int s1, s2, l1, l2, n_strobe;
    i_reset = 1'b1;
    i_pc = 16'h0000;
    i_rd = 1'b0;
    i_load_en = 1'b0;
    i_load_addr = 8'h00;
    i_load_data = 16'h0000;
    model_reset();
    @(negedge clk);
    chk("reset_dout", 32'(o_dout), 32'h0);
    chk("reset_complete", 32'(o_complete), 32'h0);
    chk("reset_busy", 32'(o_busy), 32'h0);

    // preload while reset is held: writes must still happen
    for (int a = 0; a < 256; a++) load(8'(a), 16'($urandom));
    chk("reset_busy_after_load", 32'(o_busy), 32'h0);
    i_reset = 1'b0;
    @(negedge clk);

    // 1: basic fetch, single-cycle strobe, data held
    load(8'h10, 16'h1234);
    fetch(16'h0010, 1'b0, 1'b0, 16'h0, s1, l1);
    chk("t1_dout", 32'(o_dout), 32'h1234);
    @(negedge clk);
    chk("t1_strobe_one_cycle", 32'(o_complete), 32'h0);
    chk("t1_dout_held", 32'(o_dout), 32'h1234);

    // 2: back-to-back fetches, pc scrambled during WAIT
    load(8'h10, 16'hAAAA);
    load(8'h11, 16'hBBBB);
    fetch(16'h0010, 1'b0, 1'b0, 16'h0, s1, l1);
    chk("t2_first", 32'(o_dout), 32'hAAAA);
    fetch(16'h0011, 1'b0, 1'b0, 16'h0, s2, l2);
    chk("t2_second", 32'(o_dout), 32'hBBBB);
    chk("t2_spacing", 32'(s2 - s1), 32'(l2 + 1));

    // 3: out-of-range pc returns NOP, not ram[0]
    load(8'h00, 16'h7777);
    fetch(16'h0100, 1'b0, 1'b0, 16'h0, s1, l1);
    chk("t3_oor", 32'(o_dout), 32'h0000);

    // 4: load collides with RESP edge
    load(8'h20, 16'h5555);
    fetch(16'h0020, 1'b0, 1'b1, 16'h6666, s1, l1);
    chk("t4_old_data", 32'(o_dout), 32'h5555);
    @(negedge clk);
    fetch(16'h0020, 1'b1, 1'b0, 16'h0, s1, l1);
    chk("t4_new_data", 32'(o_dout), 32'h6666);

    // 5: reset during WAIT
    i_pc = 16'h0011;
    i_rd = 1'b1;
    l1 = next_latency();
    @(posedge clk);
    @(negedge clk);
    i_rd = 1'b0;
    chk("t5_busy_before", 32'(o_busy), 32'h1);
    #2 i_reset = 1'b1;
    #1;
    chk("t5_async_dout", 32'(o_dout), 32'h0);
    chk("t5_async_complete", 32'(o_complete), 32'h0);
    chk("t5_async_busy", 32'(o_busy), 32'h0);
    model_reset();
    @(negedge clk);
    i_reset = 1'b0;
    n_strobe = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (o_complete) n_strobe++;
    end
    chk("t5_no_strobe", 32'(n_strobe), 32'h0);
    fetch(16'h0011, 1'b0, 1'b0, 16'h0, s1, l1);
    chk("t5_after_release", 32'(o_dout), 32'hBBBB);

    // 6: randomized fetches, loads and gaps
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) load(8'($urandom), 16'($urandom));
      fetch(16'($urandom_range(0, 511)), 1'($urandom_range(0, 1)), 1'b0, 16'h0, s1, l1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
